// File: rtl/bus_arbiter_pkg.sv
// Shared types, default sizes and helpers for the round-robin bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned AW_DEF        = 16;
    localparam int unsigned DW_DEF        = 16;
    localparam int unsigned MAX_BURST_DEF = 8;
    localparam int unsigned MAX_NREQ      = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Index of the set bit in a one-hot vector (zero when none is set).
    function automatic logic [2:0] oh_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin requester selection: first set request scanning upward from last+1, modulo NREQ.
module bus_arbiter_rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic            pick_valid
);

    int unsigned idx;

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            if (!pick_valid && req[IW'(idx)]) begin
                pick[IW'(idx)] = 1'b1;
                pick_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: shares one address/data/write bus between NREQ masters with a
// burst cap on grant tenure and a registered read-return path.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk_bus,
    input  logic              rst_bus,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_dout,
    input  logic [NREQ-1:0]   req_write,
    output logic [NREQ-1:0]   gnt,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_dout,
    output logic              bus_write,
    input  logic [DW-1:0]     bus_din,
    output logic [DW-1:0]     rdata,
    output logic [NREQ-1:0]   rvalid,
    output logic              busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   burst_q, burst_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic [NREQ-1:0] sel;
    logic            txn;
    logic            txn_write;
    logic            others;
    logic            cap_hit;

    bus_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req        (req),
        .last       (last_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    assign sel       = gnt_q & req;
    assign txn       = |sel;
    assign txn_write = |(sel & req_write);
    assign others    = |(req & ~gnt_q);
    assign cap_hit   = txn && (burst_q == CW'(MAX_BURST - 1));

    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rvalid_q <= '0;
            last_q   <= IW'(NREQ - 1);
            burst_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            rdata_q  <= rdata_d;
        end
    end

    // Release on dropped request, or on the cap when someone else is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_GRANT;
            ST_GRANT: if (!txn || (cap_hit && others)) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = gnt_q;
        last_d   = last_q;
        burst_d  = burst_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick;
                    last_d  = IW'(oh_to_idx(MAX_NREQ'(pick)));
                    burst_d = '0;
                end
            end
            ST_GRANT: begin
                if (txn) begin
                    burst_d = cap_hit ? '0 : burst_q + CW'(1);
                    if (!txn_write) begin
                        rdata_d  = bus_din;
                        rvalid_d = gnt_q;
                    end
                end
                if (state_d == ST_IDLE) begin
                    gnt_d   = '0;
                    burst_d = '0;
                end
            end
        endcase
    end

    // Bus is driven only by a granted master that is actually requesting.
    always_comb begin
        bus_addr  = '0;
        bus_dout  = '0;
        bus_write = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel[i]) begin
                bus_addr  = req_addr[i*AW +: AW];
                bus_dout  = req_dout[i*DW +: DW];
                bus_write = req_write[i];
            end
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign busy   = |gnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a tenure model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_dout;
    logic [N-1:0]    req_write;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_dout;
    logic            bus_write;
    logic [DW-1:0]   bus_din;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    rvalid;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 = none), last owner, transactions in this tenure, read return.
    int          m_owner;
    int          m_last;
    int          m_n;
    int          m_rvalid;
    logic [15:0] m_rdata;

    bus_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk_bus   (clk),
        .rst_bus   (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_dout  (req_dout),
        .req_write (req_write),
        .gnt       (gnt),
        .bus_addr  (bus_addr),
        .bus_dout  (bus_dout),
        .bus_write (bus_write),
        .bus_din   (bus_din),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_last   = N - 1;
        m_n      = 0;
        m_rvalid = 0;
        m_rdata  = '0;
    endtask

    function automatic int exp_gnt();
        return (m_owner < 0) ? 0 : (1 << m_owner);
    endfunction

    // One bus cycle: check the bus mux, advance the model across the edge, check registered outputs.
    task automatic cycle();
        int          n_owner, n_last, n_n, n_rvalid;
        logic [15:0] n_rdata;
        logic [31:0] ea, ed, ew;
        #1;
        ea = 0; ed = 0; ew = 0;
        if (m_owner >= 0 && req[m_owner]) begin
            ea = 32'(req_addr[m_owner*AW +: AW]);
            ed = 32'(req_dout[m_owner*DW +: DW]);
            ew = 32'(req_write[m_owner]);
        end
        check("bus_addr", 32'(bus_addr), ea);
        check("bus_dout", 32'(bus_dout), ed);
        check("bus_write", 32'(bus_write), ew);

        n_owner  = m_owner;
        n_last   = m_last;
        n_n      = m_n;
        n_rvalid = 0;
        n_rdata  = m_rdata;
        if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                if (n_owner < 0 && req[(m_last + i) % N]) n_owner = (m_last + i) % N;
            end
            if (n_owner >= 0) begin
                n_last = n_owner;
                n_n    = 0;
            end
        end else if (!req[m_owner]) begin
            n_owner = -1;
        end else begin
            n_n = m_n + 1;
            if (!req_write[m_owner]) begin
                n_rdata  = bus_din;
                n_rvalid = 1 << m_owner;
            end
            if ((n_n % MB) == 0 && (32'(req) & ~(32'(1) << m_owner)) != 0) n_owner = -1;
        end

        @(posedge clk);
        #1;
        m_owner  = n_owner;
        m_last   = n_last;
        m_n      = n_n;
        m_rvalid = n_rvalid;
        m_rdata  = n_rdata;
        check("gnt", 32'(gnt), 32'(exp_gnt()));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("rvalid", 32'(rvalid), 32'(m_rvalid));
        check("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        req_write = '0;
        #1;
        model_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_bus_write", 32'(bus_write), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_dout  = '0;
        req_write = '0;
        bus_din   = '0;

        // Single read by master 0
        do_reset();
        req                 = 4'b0001;
        req_addr[0*AW +: AW] = 16'h0010;
        bus_din             = 16'hBEEF;
        cycle();
        check("t1_gnt", 32'(gnt), 32'h1);
        #1;
        check("t1_addr", 32'(bus_addr), 32'h0010);
        cycle();
        check("t1_rdata", 32'(rdata), 32'hBEEF);
        check("t1_rvalid", 32'(rvalid), 32'h1);
        req = '0;
        cycle();

        // All masters requesting: 8-transaction tenures in order 0,1,2,3,0 with one dead cycle
        do_reset();
        req = 4'b1111;
        cycle();
        for (int c = 0; c < 38; c++) begin
            check("t2_rr", 32'(gnt), ((c % 9) < 8) ? (32'(1) << ((c / 9) % 4)) : 32'h0);
            bus_din = 16'($urandom);
            cycle();
        end

        // Lone requester keeps the grant across the burst cap
        do_reset();
        req = 4'b0100;
        cycle();
        for (int c = 0; c < 20; c++) begin
            check("t3_hold", 32'(gnt), 32'h4);
            cycle();
        end

        // Single write by master 1, then request drops
        do_reset();
        req                  = 4'b0010;
        req_write            = 4'b0010;
        req_addr[1*AW +: AW] = 16'h00FF;
        req_dout[1*DW +: DW] = 16'h1234;
        cycle();
        #1;
        check("t4_write", 32'(bus_write), 32'h1);
        check("t4_addr", 32'(bus_addr), 32'h00FF);
        check("t4_dout", 32'(bus_dout), 32'h1234);
        cycle();
        req = '0;
        #1;
        check("t4_write_off", 32'(bus_write), 32'h0);
        cycle();
        check("t4_release", 32'(gnt), 32'h0);

        // Asynchronous reset in the middle of master 3's burst
        do_reset();
        req       = 4'b1000;
        req_write = 4'b0000;
        bus_din   = 16'h5A5A;
        cycle();
        cycle();
        req_write = 4'b1000;
        #1;
        check("t5_pre_write", 32'(bus_write), 32'h1);
        check("t5_pre_rvalid", 32'(rvalid), 32'h8);
        rst = 1'b1;
        #1;
        model_reset();
        check("t5_async_gnt", 32'(gnt), 32'h0);
        check("t5_async_write", 32'(bus_write), 32'h0);
        check("t5_async_rvalid", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req       = 4'b1111;
        req_write = 4'b0000;
        cycle();
        check("t5_first", 32'(gnt), 32'h1);

        // Master 0 drops at its cap cycle with master 1 waiting: one release, one dead cycle
        do_reset();
        req = 4'b0001;
        cycle();
        req = 4'b0011;
        for (int c = 0; c < 7; c++) cycle();
        req = 4'b0010;
        cycle();
        check("t6_dead", 32'(gnt), 32'h0);
        cycle();
        check("t6_next", 32'(gnt), 32'h2);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) req[i] = ~req[i];
            end
            req_addr  = {$urandom, $urandom};
            req_dout  = {$urandom, $urandom};
            req_write = 4'($urandom);
            bus_din   = 16'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
